// File: rtl/digit_seq_pkg.sv
// Shared constants and helpers for the programmable digit sequencer and its prescaler.
package digit_seq_pkg;

  localparam logic [19:0] DEFAULT_TABLE = 20'h87212;

  localparam logic FWD = 1'b1;
  localparam logic BWD = 1'b0;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count while enabled, restart after the terminal count, park at zero when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!en) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == LAST_C) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = en & (cnt_r == LAST_C);

endmodule

// File: rtl/digit_sequencer.sv
// One-hot sequencer walking a rewritable digit table forward or backward with wrap-around,
// advanced by step pulses, the auto-advance tick, or a direct load.
module digit_sequencer
  import digit_seq_pkg::*;
#(
  parameter int                            NUM_DIGITS = 5,
  parameter int                            DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_INIT = DEFAULT_TABLE,
  parameter int                            TICK_DIV   = 50_000_000,
  parameter int                            IDX_W      = idx_width(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dir,
  input  logic               step,
  input  logic               auto_en,
  input  logic               load_en,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [DIGIT_W-1:0] wr_data,
  output logic [DIGIT_W-1:0] out,
  output logic [IDX_W-1:0]   idx,
  output logic               wrap
);

  localparam logic [IDX_W:0]        NUM_C  = (IDX_W + 1)'(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_C = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_C  = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0] state_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DIGIT_W-1:0]    out_r;
  logic                  wrap_r;
  logic [DIGIT_W-1:0]    table_r [NUM_DIGITS];

  logic [IDX_W-1:0]      cur_idx_s;
  logic [IDX_W:0]        hot_cnt_s;
  logic                  legal_s;
  logic                  tick_s;
  logic                  adv_s;
  logic                  load_ok_s;
  logic                  wr_ok_s;
  logic [IDX_W-1:0]      nxt_idx_s;
  logic [NUM_DIGITS-1:0] nxt_state_s;
  logic                  nxt_wrap_s;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (auto_en),
    .tick (tick_s)
  );

  // Binary-encode the one-hot state and flag anything that is not exactly one hot.
  always_comb begin
    cur_idx_s = {IDX_W{1'b0}};
    hot_cnt_s = {(IDX_W + 1){1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (state_r[i]) begin
        cur_idx_s = cur_idx_s | IDX_W'(i);
        hot_cnt_s = hot_cnt_s + (IDX_W + 1)'(1);
      end else begin
        cur_idx_s = cur_idx_s;
      end
    end
    legal_s = (hot_cnt_s == (IDX_W + 1)'(1));
  end

  // Next index: recovery, then load, then advance, else hold.
  always_comb begin
    nxt_idx_s  = cur_idx_s;
    nxt_wrap_s = 1'b0;
    adv_s      = step | (auto_en & tick_s);
    load_ok_s  = load_en & ({1'b0, load_idx} < NUM_C);
    wr_ok_s    = wr_en & ({1'b0, wr_idx} < NUM_C);
    if (!legal_s) begin
      nxt_idx_s = {IDX_W{1'b0}};
    end else if (load_en) begin
      // An out-of-range load still wins priority, so it also swallows any advance.
      if (load_ok_s) begin
        nxt_idx_s = load_idx;
      end else begin
        nxt_idx_s = cur_idx_s;
      end
    end else if (adv_s) begin
      if (dir == FWD) begin
        if (cur_idx_s == LAST_C) begin
          nxt_idx_s  = {IDX_W{1'b0}};
          nxt_wrap_s = 1'b1;
        end else begin
          nxt_idx_s = cur_idx_s + IDX_W'(1);
        end
      end else begin
        if (cur_idx_s == {IDX_W{1'b0}}) begin
          nxt_idx_s  = LAST_C;
          nxt_wrap_s = 1'b1;
        end else begin
          nxt_idx_s = cur_idx_s - IDX_W'(1);
        end
      end
    end else begin
      nxt_idx_s = cur_idx_s;
    end
    nxt_state_s = ONE_C << nxt_idx_s;
  end

  // Sequencer state, index and wrap flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ONE_C;
      idx_r   <= {IDX_W{1'b0}};
      wrap_r  <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      idx_r   <= nxt_idx_s;
      wrap_r  <= nxt_wrap_s;
    end
  end

  // Digit table with run-time rewrite.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        table_r[i] <= DIGIT_INIT[i*DIGIT_W +: DIGIT_W];
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_ok_s && (wr_idx == IDX_W'(i))) begin
          table_r[i] <= wr_data;
        end else begin
          table_r[i] <= table_r[i];
        end
      end
    end
  end

  // Output digit tracks the post-edge table at the post-edge index, bypassing a same-cycle write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r <= DIGIT_INIT[DIGIT_W-1:0];
    end else if (wr_ok_s && (wr_idx == nxt_idx_s)) begin
      out_r <= wr_data;
    end else begin
      out_r <= table_r[nxt_idx_s];
    end
  end

  assign out  = out_r;
  assign idx  = idx_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_digit_sequencer.sv
// Randomised and directed bench for digit_sequencer against a behavioural table/index model.
module tb_digit_sequencer;

  localparam int N  = 5;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       dir, step, auto_en, load_en, wr_en;
  logic [2:0] load_idx, wr_idx;
  logic [3:0] wr_data;
  logic [3:0] out;
  logic [2:0] idx;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  int m_idx, m_pc, m_wrap;
  int m_tbl [N];
  int exp_fwd_out [5] = '{1, 2, 7, 8, 2};
  int exp_fwd_idx [5] = '{1, 2, 3, 4, 0};

  digit_sequencer #(
    .NUM_DIGITS (N),
    .DIGIT_W    (4),
    .DIGIT_INIT (20'h87212),
    .TICK_DIV   (TD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dir      (dir),
    .step     (step),
    .auto_en  (auto_en),
    .load_en  (load_en),
    .load_idx (load_idx),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .out      (out),
    .idx      (idx),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx  = 0;
    m_pc   = 0;
    m_wrap = 0;
    m_tbl  = '{2, 1, 2, 7, 8};
  endtask

  task automatic clear_inputs();
    dir = 1'b1; step = 1'b0; auto_en = 1'b0; load_en = 1'b0;
    load_idx = 3'd0; wr_en = 1'b0; wr_idx = 3'd0; wr_data = 4'd0;
  endtask

  // Apply current inputs to the model, clock the DUT, then compare.
  task automatic cycle();
    int tick, adv;
    tick = (auto_en && m_pc == TD - 1) ? 1 : 0;
    m_pc = auto_en ? ((m_pc + 1) % TD) : 0;
    adv  = (step || tick) ? 1 : 0;
    m_wrap = 0;
    if (load_en) begin
      if (load_idx < N) m_idx = load_idx;
    end else if (adv) begin
      if (dir) begin
        m_wrap = (m_idx == N - 1) ? 1 : 0;
        m_idx  = (m_idx + 1) % N;
      end else begin
        m_wrap = (m_idx == 0) ? 1 : 0;
        m_idx  = (m_idx + N - 1) % N;
      end
    end
    if (wr_en && wr_idx < N) m_tbl[wr_idx] = wr_data;
    @(posedge clk);
    #1;
    chk("out", out, m_tbl[m_idx]);
    chk("idx", idx, m_idx);
    chk("wrap", wrap, m_wrap);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    chk("rst_out", out, 2);
    chk("rst_idx", idx, 0);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    #12;
    chk("reset_out", out, 2);
    chk("reset_idx", idx, 0);
    chk("reset_wrap", wrap, 0);
    rst = 1'b1;
    repeat (10) cycle();

    // forward steps with wrap on the fifth
    for (int k = 0; k < 5; k++) begin
      dir = 1'b1; step = 1'b1;
      cycle();
      chk("fwd_out_tab", out, exp_fwd_out[k]);
      chk("fwd_idx_tab", idx, exp_fwd_idx[k]);
      chk("fwd_wrap_tab", wrap, (k == 4) ? 1 : 0);
      step = 1'b0;
      cycle();
    end

    // backward from reset
    pulse_reset();
    dir = 1'b0; step = 1'b1;
    cycle();
    chk("bwd_out", out, 8);
    chk("bwd_wrap", wrap, 1);
    step = 1'b0;
    cycle();
    chk("bwd_wrap_clr", wrap, 0);
    step = 1'b1;
    cycle();
    chk("bwd_out2", out, 7);
    step = 1'b0;

    // auto-advance, interrupted and resumed
    dir = 1'b1; auto_en = 1'b1;
    repeat (10) cycle();
    auto_en = 1'b0;
    repeat (3) cycle();
    auto_en = 1'b1;
    repeat (9) cycle();
    auto_en = 1'b0;

    // table writes: in-place and bypass on advance
    load_en = 1'b1; load_idx = 3'd3;
    cycle();
    load_en = 1'b0;
    wr_en = 1'b1; wr_idx = 3'd3; wr_data = 4'd9;
    cycle();
    chk("wr_inplace", out, 9);
    step = 1'b1; dir = 1'b1; wr_idx = 3'd4; wr_data = 4'd5;
    cycle();
    chk("wr_bypass_out", out, 5);
    chk("wr_bypass_idx", idx, 4);
    step = 1'b0; wr_en = 1'b0;

    // load beats step; out-of-range load holds
    load_en = 1'b1; load_idx = 3'd2; step = 1'b1;
    cycle();
    chk("load_idx", idx, 2);
    chk("load_out", out, 2);
    load_idx = 3'd6;
    cycle();
    chk("load_bad_hold", idx, 2);
    clear_inputs();

    // asynchronous reset during an auto run
    auto_en = 1'b1;
    repeat (6) cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("async_out", out, 2);
    chk("async_idx", idx, 0);
    chk("async_wrap", wrap, 0);
    model_reset();
    #1;
    rst = 1'b1;
    repeat (5) cycle();

    // randomised traffic
    for (int c = 0; c < 1500; c++) begin
      dir      = 1'($urandom_range(0, 1));
      step     = ($urandom_range(0, 2) == 0);
      load_en  = ($urandom_range(0, 11) == 0);
      load_idx = 3'($urandom_range(0, 7));
      wr_en    = ($urandom_range(0, 4) == 0);
      wr_idx   = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
      cycle();
    end
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
